// File: rtl/calc_share_sequencer.sv
// calc_share_sequencer
//   Shares one calculadora_sincrona between two requesters (A, B). A requester
//   is granted a whole burst. When both request at once, a round-robin pointer
//   picks the owner. Each accepted command is driven to the calculator for one
//   cycle. The sequencer then waits CALC_LAT cycles, captures calc_saida into
//   result and pulses the owner's done for one cycle.
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   a_valid/a_ready        requester A command handshake
//   a_codigo/a_entrada     requester A operation code / operand
//   a_last                 final command of A's burst
//   a_done                 one-cycle pulse, result valid for A
//   b_*                    same set for requester B
//   result                 last captured calc_saida
//   timeout_err            one-cycle pulse when an idle owner loses the grant
//   calc_reset             calculator reset (reset input or grant-time clear)
//   calc_codigo            calculator operation code (registered)
//   calc_entrada           calculator operand (registered)
//   calc_saida             calculator output
module calc_share_sequencer #(
   parameter int unsigned CALC_LAT       = 1,
   parameter logic [2:0]  NOP_CODE       = 3'b000,
   parameter bit          CLEAR_ON_GRANT = 1'b1,
   parameter int unsigned IDLE_TIMEOUT   = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_valid,
   output logic       a_ready,
   input  logic [2:0] a_codigo,
   input  logic [7:0] a_entrada,
   input  logic       a_last,
   output logic       a_done,
   input  logic       b_valid,
   output logic       b_ready,
   input  logic [2:0] b_codigo,
   input  logic [7:0] b_entrada,
   input  logic       b_last,
   output logic       b_done,
   output logic [7:0] result,
   output logic       timeout_err,
   output logic       calc_reset,
   output logic [2:0] calc_codigo,
   output logic [7:0] calc_entrada,
   input  logic [7:0] calc_saida
);

   localparam int unsigned LAT_W  = 3;
   localparam int unsigned IDLE_W = 8;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLR    = 3'd1;
   localparam logic [2:0] S_ACCEPT = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;

   logic [2:0]        state_q, state_d;
   logic              owner_q, owner_d;       // 0: A, 1: B
   logic              rr_q, rr_d;             // 0: A favoured on contention
   logic              last_q, last_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic              a_ready_q, a_ready_d;
   logic              b_ready_q, b_ready_d;
   logic              a_done_q, a_done_d;
   logic              b_done_q, b_done_d;
   logic [7:0]        result_q, result_d;
   logic              timeout_q, timeout_d;
   logic [2:0]        calc_codigo_q, calc_codigo_d;
   logic [7:0]        calc_entrada_q, calc_entrada_d;

   // Owner-side view of the request inputs
   logic       own_valid;
   logic [2:0] own_codigo;
   logic [7:0] own_entrada;
   logic       own_last;

   assign own_valid   = owner_q ? b_valid   : a_valid;
   assign own_codigo  = owner_q ? b_codigo  : a_codigo;
   assign own_entrada = owner_q ? b_entrada : a_entrada;
   assign own_last    = owner_q ? b_last    : a_last;

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         owner_q        <= 1'b0;
         rr_q           <= 1'b0;
         last_q         <= 1'b0;
         lat_cnt_q      <= '0;
         idle_cnt_q     <= '0;
         a_ready_q      <= 1'b0;
         b_ready_q      <= 1'b0;
         a_done_q       <= 1'b0;
         b_done_q       <= 1'b0;
         result_q       <= '0;
         timeout_q      <= 1'b0;
         calc_codigo_q  <= NOP_CODE;
         calc_entrada_q <= '0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         rr_q           <= rr_d;
         last_q         <= last_d;
         lat_cnt_q      <= lat_cnt_d;
         idle_cnt_q     <= idle_cnt_d;
         a_ready_q      <= a_ready_d;
         b_ready_q      <= b_ready_d;
         a_done_q       <= a_done_d;
         b_done_q       <= b_done_d;
         result_q       <= result_d;
         timeout_q      <= timeout_d;
         calc_codigo_q  <= calc_codigo_d;
         calc_entrada_q <= calc_entrada_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      rr_d           = rr_q;
      last_d         = last_q;
      lat_cnt_d      = lat_cnt_q;
      idle_cnt_d     = idle_cnt_q;
      a_done_d       = 1'b0;
      b_done_d       = 1'b0;
      result_d       = result_q;
      timeout_d      = 1'b0;
      calc_codigo_d  = NOP_CODE;
      calc_entrada_d = calc_entrada_q;

      case (state_q)
         S_IDLE: begin
            if (a_valid || b_valid) begin
               owner_d    = (a_valid && b_valid) ? rr_q : b_valid;
               idle_cnt_d = '0;
               state_d    = CLEAR_ON_GRANT ? S_CLR : S_ACCEPT;
            end
         end
         S_CLR: begin
            idle_cnt_d = '0;
            state_d    = S_ACCEPT;
         end
         S_ACCEPT: begin
            if (own_valid) begin
               // Command goes to the calculator for exactly the next cycle
               calc_codigo_d  = own_codigo;
               calc_entrada_d = own_entrada;
               last_d         = own_last;
               lat_cnt_d      = LAT_W'(CALC_LAT);
               idle_cnt_d     = '0;
               state_d        = S_WAIT;
            end else if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
               timeout_d  = 1'b1;
               rr_d       = ~rr_q;
               idle_cnt_d = '0;
               state_d    = S_IDLE;
            end else begin
               idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
         end
         S_WAIT: begin
            if (lat_cnt_q == '0) begin
               result_d = calc_saida;
               a_done_d = ~owner_q;
               b_done_d = owner_q;
               state_d  = S_RESP;
            end else begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
         end
         S_RESP: begin
            if (last_q) begin
               rr_d    = ~rr_q;
               state_d = S_IDLE;
            end else begin
               idle_cnt_d = '0;
               state_d    = S_ACCEPT;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Only the owner sees ready, and only while accepting
      a_ready_d = (state_d == S_ACCEPT) && !owner_d;
      b_ready_d = (state_d == S_ACCEPT) && owner_d;
   end

   assign a_ready      = a_ready_q;
   assign b_ready      = b_ready_q;
   assign a_done       = a_done_q;
   assign b_done       = b_done_q;
   assign result       = result_q;
   assign timeout_err  = timeout_q;
   assign calc_codigo  = calc_codigo_q;
   assign calc_entrada = calc_entrada_q;
   // Calculator is held in reset with the sequencer and cleared on each grant
   assign calc_reset   = reset | (state_q == S_CLR);

endmodule

// File: tb/tb_calc_share_sequencer.sv
// Directed bench for calc_share_sequencer.
// Instance u_dut: CALC_LAT=1, CLEAR_ON_GRANT=1, IDLE_TIMEOUT=4.
// Instance u_lat3: CALC_LAT=3, CLEAR_ON_GRANT=0, shares the same requester inputs.
// Both calculator models compute saida = entrada + codigo.
module tb_calc_share_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       a_valid, a_last, b_valid, b_last;
   logic [2:0] a_codigo, b_codigo;
   logic [7:0] a_entrada, b_entrada;

   logic       a_ready, b_ready, a_done, b_done, timeout_err, calc_reset;
   logic [7:0] result, calc_entrada, calc_saida;
   logic [2:0] calc_codigo;

   logic       x_a_ready, x_b_ready, x_a_done, x_b_done, x_timeout_err, x_calc_reset;
   logic [7:0] x_result, x_calc_entrada, x_calc_saida;
   logic [2:0] x_calc_codigo;

   int n_total = 0;
   int n_bad   = 0;

   logic mon_en     = 1'b0;
   logic b_rdy_seen = 1'b0;

   always #5 clk = ~clk;

   calc_share_sequencer #(
      .CALC_LAT(1), .NOP_CODE(3'b000), .CLEAR_ON_GRANT(1'b1), .IDLE_TIMEOUT(4)
   ) u_dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_codigo(a_codigo), .a_entrada(a_entrada),
      .a_last(a_last), .a_done(a_done),
      .b_valid(b_valid), .b_ready(b_ready), .b_codigo(b_codigo), .b_entrada(b_entrada),
      .b_last(b_last), .b_done(b_done),
      .result(result), .timeout_err(timeout_err), .calc_reset(calc_reset),
      .calc_codigo(calc_codigo), .calc_entrada(calc_entrada), .calc_saida(calc_saida)
   );

   calc_share_sequencer #(
      .CALC_LAT(3), .NOP_CODE(3'b000), .CLEAR_ON_GRANT(1'b0), .IDLE_TIMEOUT(15)
   ) u_lat3 (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(x_a_ready), .a_codigo(a_codigo), .a_entrada(a_entrada),
      .a_last(a_last), .a_done(x_a_done),
      .b_valid(b_valid), .b_ready(x_b_ready), .b_codigo(b_codigo), .b_entrada(b_entrada),
      .b_last(b_last), .b_done(x_b_done),
      .result(x_result), .timeout_err(x_timeout_err), .calc_reset(x_calc_reset),
      .calc_codigo(x_calc_codigo), .calc_entrada(x_calc_entrada), .calc_saida(x_calc_saida)
   );

   // Calculator model, one register stage
   always_ff @(posedge clk) begin
      if (calc_reset) calc_saida <= '0;
      else            calc_saida <= calc_entrada + {5'b0, calc_codigo};
   end

   // Calculator model, three register stages
   logic [7:0] p1, p2;
   always_ff @(posedge clk) begin
      if (x_calc_reset) begin
         p1 <= '0; p2 <= '0; x_calc_saida <= '0;
      end else begin
         p1           <= x_calc_entrada + {5'b0, x_calc_codigo};
         p2           <= p1;
         x_calc_saida <= p2;
      end
   end

   // Records any b_ready seen while A owns a burst
   always @(negedge clk) begin
      if (mon_en && b_ready) b_rdy_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Waits (bounded) for the chosen requester's ready on u_dut; the other must stay low
   task automatic wait_rdy(input string tag, input bit use_b, input int budget);
      int n;
      n = 0;
      while (!(use_b ? b_ready : a_ready) && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(use_b ? b_ready : a_ready), 32'd1);
      check({tag, "_other"}, 32'(use_b ? a_ready : b_ready), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int nop_n;
      reset = 1'b1;
      a_valid = 1'b0; a_codigo = '0; a_entrada = '0; a_last = 1'b0;
      b_valid = 1'b0; b_codigo = '0; b_entrada = '0; b_last = 1'b0;
      tick();
      tick();

      // Reset values
      check("rst_a_ready", 32'(a_ready), 0);
      check("rst_b_ready", 32'(b_ready), 0);
      check("rst_done", 32'({a_done, b_done}), 0);
      check("rst_result", 32'(result), 0);
      check("rst_timeout", 32'(timeout_err), 0);
      check("rst_calc_codigo", 32'(calc_codigo), 0);
      check("rst_calc_entrada", 32'(calc_entrada), 0);
      check("rst_calc_reset", 32'(calc_reset), 1);
      reset = 1'b0;
      tick();

      // Single A command with grant-time clear
      a_valid = 1'b1; a_codigo = 3'd1; a_entrada = 8'h05; a_last = 1'b1;
      tick();
      check("t1_clr_calc_reset", 32'(calc_reset), 1);
      check("t1_clr_a_ready", 32'(a_ready), 0);
      tick();
      check("t1_a_ready", 32'(a_ready), 1);
      check("t1_calc_reset_off", 32'(calc_reset), 0);
      tick();
      a_valid = 1'b0;
      check("t1_issue_codigo", 32'(calc_codigo), 1);
      check("t1_issue_entrada", 32'(calc_entrada), 32'h05);
      check("t1_a_ready_low", 32'(a_ready), 0);
      tick();
      check("t1_nop_codigo", 32'(calc_codigo), 0);
      check("t1_entrada_held", 32'(calc_entrada), 32'h05);
      check("t1_no_early_done", 32'(a_done), 0);
      tick();
      check("t1_a_done", 32'(a_done), 1);
      check("t1_result", 32'(result), 32'h06);
      check("t1_b_done", 32'(b_done), 0);
      tick();
      check("t1_done_one_cycle", 32'(a_done), 0);
      check("t1_result_held", 32'(result), 32'h06);

      // Simultaneous requests: A first; on the next contention B first
      do_reset();
      a_valid = 1'b1; a_codigo = 3'd2; a_entrada = 8'h0A; a_last = 1'b1;
      b_valid = 1'b1; b_codigo = 3'd3; b_entrada = 8'h14; b_last = 1'b1;
      tick();
      tick();
      check("t2_a_first", 32'(a_ready), 1);
      check("t2_b_blocked", 32'(b_ready), 0);
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      check("t2_a_done", 32'(a_done), 1);
      check("t2_a_result", 32'(result), 32'h0C);
      a_valid = 1'b1; a_codigo = 3'd1; a_entrada = 8'h01; a_last = 1'b1;
      tick();
      tick();
      tick();
      check("t2_b_next", 32'(b_ready), 1);
      check("t2_a_waits", 32'(a_ready), 0);
      tick();
      b_valid = 1'b0;
      tick();
      tick();
      check("t2_b_done", 32'(b_done), 1);
      check("t2_b_result", 32'(result), 32'h17);
      check("t2_a_no_done", 32'(a_done), 0);
      wait_rdy("t2_a_pending", 1'b0, 8);
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      check("t2_a2_done", 32'(a_done), 1);
      check("t2_a2_result", 32'(result), 32'h02);

      // Three-command A burst while B waits
      do_reset();
      b_valid = 1'b1; b_codigo = 3'd1; b_entrada = 8'h50; b_last = 1'b1;
      a_valid = 1'b1; a_codigo = 3'd1; a_entrada = 8'h10; a_last = 1'b0;
      mon_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_rdy("t3_a_rdy", 1'b0, 8);
         tick();
         a_codigo  = 3'(k + 2);
         a_entrada = 8'(16 * (k + 2));
         a_last    = (k == 1);
         if (k == 2) a_valid = 1'b0;
         tick();
         tick();
         check("t3_a_done", 32'(a_done), 1);
         check("t3_result", 32'(result), 32'(8'(17 * (k + 1))));
         if (k < 2) begin
            tick();
            check("t3_back_to_back", 32'(a_ready), 1);
         end
      end
      check("t3_b_held_off", 32'(b_rdy_seen), 0);
      mon_en = 1'b0;
      wait_rdy("t3_b_grant", 1'b1, 8);
      tick();
      b_valid = 1'b0;
      tick();
      tick();
      check("t3_b_done", 32'(b_done), 1);
      check("t3_b_result", 32'(result), 32'h51);

      // Idle owner times out, grant moves to B; then reset during B's WAIT
      do_reset();
      a_valid = 1'b1; a_codigo = 3'd1; a_entrada = 8'h01; a_last = 1'b0;
      b_valid = 1'b1; b_codigo = 3'd2; b_entrada = 8'h40; b_last = 1'b0;
      wait_rdy("t4_a_rdy", 1'b0, 8);
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      check("t4_a_done", 32'(a_done), 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t4_no_timeout_yet", 32'(timeout_err), 0);
         check("t4_a_still_ready", 32'(a_ready), 1);
      end
      tick();
      check("t4_timeout", 32'(timeout_err), 1);
      check("t4_no_done", 32'(a_done), 0);
      check("t4_a_released", 32'(a_ready), 0);
      tick();
      check("t4_timeout_pulse", 32'(timeout_err), 0);
      tick();
      check("t4_b_granted", 32'(b_ready), 1);
      tick();
      b_valid = 1'b0;
      reset = 1'b1;
      tick();
      check("t5_rst_no_done", 32'(b_done), 0);
      check("t5_rst_codigo", 32'(calc_codigo), 0);
      check("t5_rst_entrada", 32'(calc_entrada), 0);
      check("t5_rst_result", 32'(result), 0);
      check("t5_rst_calc_reset", 32'(calc_reset), 1);
      check("t5_rst_b_ready", 32'(b_ready), 0);
      reset = 1'b0;
      tick();
      check("t5_no_late_done", 32'(b_done), 0);
      a_valid = 1'b1; a_codigo = 3'd4; a_entrada = 8'h20; a_last = 1'b1;
      b_valid = 1'b1; b_codigo = 3'd2; b_entrada = 8'h40; b_last = 1'b1;
      wait_rdy("t5_a_favoured", 1'b0, 8);
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      check("t5_a_result", 32'(result), 32'h24);
      wait_rdy("t5_b_after", 1'b1, 8);
      tick();
      b_valid = 1'b0;
      tick();
      tick();
      check("t5_b_done", 32'(b_done), 1);
      check("t5_b_result", 32'(result), 32'h42);

      // CALC_LAT=3 instance without grant-time clear
      do_reset();
      a_valid = 1'b1; a_codigo = 3'd3; a_entrada = 8'h10; a_last = 1'b1;
      tick();
      check("t6_a_ready", 32'(x_a_ready), 1);
      check("t6_no_calc_reset", 32'(x_calc_reset), 0);
      tick();
      a_valid = 1'b0;
      nop_n = 0;
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) tick();
         if (x_calc_codigo != 3'b000) nop_n++;
         check("t6_done_timing", 32'(x_a_done), 32'(k == 5));
      end
      check("t6_result", 32'(x_result), 32'h13);
      check("t6_issue_cycles", 32'(nop_n), 1);
      tick();
      check("t6_done_one_cycle", 32'(x_a_done), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
